// File: rtl/multiply_seq.sv
// Iterative radix-2 shift-add multiplier: one product per accepted start, result held until the next.
// Optional build macro MUL_EARLY_TERM_EN stops iterating once no multiplier bits remain set.
module multiply_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 sign,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 ready
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]           state;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mb;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_sh;
  logic [2*WIDTH-1:0]   acc_step;
  logic                 last;

  // Magnitude of a two's-complement operand; the most-negative value maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] abs_op(input logic [WIDTH-1:0] v, input logic s);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return (s && (sv < 0)) ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p, input logic n);
    return n ? (~p + (2*WIDTH)'(1)) : p;
  endfunction

  assign addend = mb[0] ? mcand : '0;
  assign sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign acc_sh = {sum, acc[WIDTH-1:1]};

`ifdef MUL_EARLY_TERM_EN
  // Once the multiplier has no set bits left, the remaining iterations are pure right shifts.
  assign last     = (cnt == CNT_W'(1)) || (mb[WIDTH-1:1] == '0);
  assign acc_step = acc_sh >> (cnt - CNT_W'(1));
`else
  assign last     = (cnt == CNT_W'(1));
  assign acc_step = acc_sh;
`endif

  assign ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mcand   <= '0;
      mb      <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      Product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand <= abs_op(multiplicand, sign);
            mb    <= abs_op(multiplier, sign);
            neg   <= sign & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            acc   <= '0;
            cnt   <= CNT_W'(WIDTH);
            state <= S_RUN;
          end
        end
        // iteration stage: conditional add into the upper half, then shift right
        S_RUN: begin
          acc <= acc_step;
          mb  <= mb >> 1;
          cnt <= cnt - CNT_W'(1);
          if (last) state <= S_FIX;
        end
        // result stage: restore sign and publish
        S_FIX: begin
          Product <= apply_sign(acc, neg);
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiply_seq.sv
// Bench for multiply_seq: directed vectors, a cycle-level reference model and per-cycle comparison.
module tb_multiply_seq;

  localparam int W = 32;

`ifdef MUL_EARLY_TERM_EN
  localparam int L_B3    = 3;
  localparam int L_B6    = 4;
  localparam int L_B0    = 2;
  localparam int L_B4    = 4;
  localparam int L_B7    = 4;
  localparam int L_B200  = 9;
  localparam int PULSE_GAP = 1;
`else
  localparam int L_B3    = 33;
  localparam int L_B6    = 33;
  localparam int L_B0    = 33;
  localparam int L_B4    = 33;
  localparam int L_B7    = 33;
  localparam int L_B200  = 33;
  localparam int PULSE_GAP = 9;
`endif
  localparam int L_TOP = 33;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [W-1:0]     mcand;
  logic [W-1:0]     mplier;
  logic             sign;
  logic [2*W-1:0]   Product;
  logic             ready;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  multiply_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .sign         (sign),
    .Product      (Product),
    .ready        (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference arithmetic: full-precision product of the operands as the sign flag interprets them.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic int ref_lat(input logic [31:0] b, input logic s);
`ifdef MUL_EARLY_TERM_EN
    longint mag;
    int top;
    mag = s ? longint'($signed(b)) : longint'({32'b0, b});
    if (mag < 0) mag = -mag;
    top = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) top = i;
    return top + 2;
`else
    return W + 1;
`endif
  endfunction

  bit          m_busy = 1'b0;
  int          m_left = 0;
  logic [63:0] m_prod = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_left = 0;
      m_prod = '0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_prod = m_pend;
      end
    end else if (start) begin
      m_busy = 1'b1;
      m_left = ref_lat(mplier, sign);
      m_pend = ref_mul(mcand, mplier, sign);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ready", {63'b0, ready}, {63'b0, !m_busy});
      check("cyc_product", Product, m_prod);
    end
  end

  task automatic wait_done(inout int lat);
    while (!ready && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!ready) check("timeout_ready", {63'b0, ready}, 64'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat);
    mcand = a; mplier = b; sign = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    wait_done(lat);
  endtask

  initial begin
    int lat;
    rst_n = 1'b1; start = 1'b0; mcand = '0; mplier = '0; sign = 1'b0;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rst_ready", {63'b0, ready}, 64'd1);
    check("rst_product", Product, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(32'd17, 32'd3, 1'b0, lat);
    check("t1_product", Product, 64'd51);
    check("t1_latency", 64'(lat), 64'(L_B3));

    run_op(32'hFFFF_FFEF, 32'd3, 1'b1, lat);
    check("t2_product", Product, 64'hFFFF_FFFF_FFFF_FFCD);
    check("t2_latency", 64'(lat), 64'(L_B3));

    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, lat);
    check("t3_minneg_product", Product, 64'h4000_0000_0000_0000);
    check("t3_minneg_latency", 64'(lat), 64'(L_TOP));

    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    check("t3_umax_product", Product, 64'hFFFF_FFFE_0000_0001);
    check("t3_umax_latency", 64'(lat), 64'(L_TOP));

    run_op(32'hFFFF_FFF9, 32'hFFFF_FFFA, 1'b1, lat);
    check("negneg_product", Product, 64'd42);
    check("negneg_latency", 64'(lat), 64'(L_B6));

    run_op(32'd0, 32'hFFFF_FFFB, 1'b1, lat);
    check("zero_signed_product", Product, 64'd0);

    run_op(32'd7, 32'd0, 1'b0, lat);
    check("t6_b0_product", Product, 64'd0);
    check("t6_b0_latency", 64'(lat), 64'(L_B0));

    run_op(32'd7, 32'd4, 1'b0, lat);
    check("t6_b4_product", Product, 64'd28);
    check("t6_b4_latency", 64'(lat), 64'(L_B4));

    // start while busy is ignored; start in the first ready cycle is taken
    mcand = 32'd17; mplier = 32'd3; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (PULSE_GAP) begin @(posedge clk); #1; end
    mcand = 32'd5; mplier = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mcand = 32'd6; mplier = 32'd7;
    lat = PULSE_GAP + 1;
    wait_done(lat);
    check("t4_product", Product, 64'd51);
    check("t4_latency", 64'(lat), 64'(L_B3));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t4_b2b_accepted", {63'b0, ready}, 64'd0);
    lat = 0;
    wait_done(lat);
    check("t4_b2b_product", Product, 64'd42);
    check("t4_b2b_latency", 64'(lat), 64'(L_B7));

    // asynchronous reset in the middle of an operation
    mcand = 32'd1234; mplier = 32'h0001_0237; sign = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    check("t5_busy_before_reset", {63'b0, ready}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_ready", {63'b0, ready}, 64'd1);
    check("t5_async_product", Product, 64'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(32'd100, 32'd200, 1'b0, lat);
    check("t5_after_product", Product, 64'd20000);
    check("t5_after_latency", 64'(lat), 64'(L_B200));

    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
